ni_flit_rebuild_scheduler: RTL and testbench
============================================

# ni_flit_rebuild_scheduler

Virtual-channel scheduler in the network interface, between the router's per-VC ejection flits and the single flit-to-packet rebuilder. It shares that one rebuild datapath among VC_NUM virtual channels. It grants one VC per packet in round-robin order and holds the grant until the packet's TAIL, so the rebuilder never sees interleaved flits. Forwarded flits are registered, and backpressure is applied per VC.

## Interface
- VC_NUM, default 4: number of virtual channels sharing the rebuilder; must be at least 2.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- vc_flit_valid  in  [VC_NUM]  per-VC flit available.
- vc_flit_in  in  flit_t [VC_NUM]  per-VC head flit.
- vc_flit_ready  out  [VC_NUM]  combinational; the VC's flit is consumed this cycle.
- sched_stall  in  1  rebuilder or packet buffer cannot accept; blocks all forwarding.
- sched_flit_valid  out  1  registered; drives the rebuilder's router_flit_valid.
- sched_flit_out  out  flit_t  registered; drives the rebuilder's router_flit_in.
- sched_active_vc  out  $clog2(VC_NUM)  registered; VC currently locked or last granted.
- sched_busy  out  1  registered; high while in LOCKED.
- sched_proto_error  out  1  sticky protocol-violation flag; tied to 0 when the macro is off.

## Operation
- FSM states are IDLE and LOCKED. Internal state is rr_ptr, locked_vc and the error flag.
- **Eligibility in IDLE:** a VC is eligible when vc_flit_valid is high. With the macro enabled, its flit_type must also be HEADER or HT.
- **Grant in IDLE:** when sched_stall=0, grant the first eligible VC scanning upward from rr_ptr, modulo VC_NUM. Assert its vc_flit_ready and register the flit onto the output.
  - Granted flit is HT: stay in IDLE and set rr_ptr = granted+1.
  - Granted flit is HEADER: go to LOCKED with locked_vc = granted.
- **LOCKED:** vc_flit_ready[locked_vc] = vc_flit_valid[locked_vc] & !sched_stall. Every other ready is 0, apart from protocol drops.
  - Consumed flit is TAIL: go to IDLE and set rr_ptr = locked_vc+1 (wrapping VC_NUM-1 to 0).
  - Consumed flit is BODY: stay in LOCKED.
- **Stall:** sched_stall=1 means no grant, no consumption and sched_flit_valid=0 next cycle. State and rr_ptr are held. Stall may assert mid-packet; the lock persists.
- **Simultaneous events:** TAIL consumed in cycle t means a new grant is possible no earlier than cycle t+1. A single-flit packet (HT) never blocks other VCs beyond its own cycle.
- **No eligible VC:** outputs go idle (sched_flit_valid=0) and rr_ptr is unchanged.
- **Reset mid-packet:** the lock is aborted and no partial flush is attempted. The rebuilder shares the same reset.

## Timing
- Latency: a flit consumed in cycle t appears on sched_flit_out with sched_flit_valid=1 in cycle t+1. Throughput is one flit per cycle.
- sched_flit_valid is a single-cycle pulse per forwarded flit. sched_flit_out holds its value when invalid.
- Reset values: sched_flit_valid=0, sched_flit_out=0, sched_active_vc=0, sched_busy=0, sched_proto_error=0, rr_ptr=0, state IDLE.
- vc_flit_ready is purely combinational from vc_flit_valid, vc_flit_in.header.flit_type, sched_stall and registered state. There is no combinational path from sched_stall to the registered outputs.

## Configuration
- Macro: NI_SCHED_PROTO_CHECK_EN.
- **Defined:**
  - BODY or TAIL flits on any unlocked VC are consumed and dropped. Their ready is asserted regardless of sched_stall and they are never forwarded.
  - HEADER or HT flits on locked_vc while in LOCKED are also dropped.
  - Several drops may occur in one cycle alongside a normal forward.
  - Every drop sets sched_proto_error, which clears only on reset.
- **Undefined:**
  - No type inspection for eligibility; any valid VC can be granted.
  - A granted BODY or TAIL in IDLE is forwarded. It is treated like HT: no lock is taken.
  - sched_proto_error is constant 0.

## Structure
- flit_t, flit_type values (HEADER, BODY, TAIL, HT) and the VC count constant stay in the shared network defines package.
- The scheduler FSM state enum is local to the block.
- One sub-module: ni_rr_arbiter. It is a parameterised round-robin one-hot picker that takes a request vector and rr_ptr and returns grant_oh and grant_idx, and it is reusable elsewhere in the NI.

## Test plan
- **Single HT:** HT on VC2 while idle -> ready[2] in cycle t, sched_flit_valid in t+1, rr_ptr=3, sched_busy stays 0.
- **Contention:** VC0 and VC1 each offer a 3-flit packet simultaneously -> output is VC0 H,B,T then VC1 H,B,T with no interleaving. sched_active_vc is 0 then 1. Minimum gap between the two packets is 1 cycle.
- **Round-robin fairness:** all 4 VCs continuously offer HT -> grant order 0,1,2,3,0,...
- **Stall:** 2-cycle sched_stall in the middle of a VC3 packet -> no ready and no valid during the stall, the lock is kept, and the packet resumes intact.
- **Reset during LOCKED:** reset asserted mid-packet -> all outputs are 0 immediately. After release, HEADER on VC1 is granted from rr_ptr=0.
- **Protocol violation (macro on):** BODY on idle VC2 -> ready[2]=1, flit not forwarded, sched_proto_error=1 and sticky until reset.

Source files
------------

// File: rtl/ni_flit_rebuild_scheduler_pkg.sv
// Shared network definitions: flit format, flit types and default VC count.
// Consumed by the NI flit-rebuild scheduler and its round-robin arbiter.
package ni_flit_rebuild_scheduler_pkg;

    localparam int NI_VC_NUM = 4;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_HT     = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e  flit_type;
        logic [5:0]  src_id;
    } flit_header_t;

    typedef struct packed {
        flit_header_t header;
        logic [31:0]  payload;
    } flit_t;

    // BODY and TAIL only make sense inside a packet that already holds a lock
    function automatic logic flit_is_cont(input flit_type_e t);
        return (t == FLIT_BODY) || (t == FLIT_TAIL);
    endfunction

endpackage

// File: rtl/ni_rr_arbiter.sv
// Parameterised round-robin one-hot picker: first request at or above ptr_i,
// wrapping modulo N. Reusable anywhere in the NI.
module ni_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [$clog2(N)-1:0]  ptr_i,
    output logic [N-1:0]          grant_oh_o,
    output logic [$clog2(N)-1:0]  grant_idx_o
);
    localparam int IW = $clog2(N);

    logic [IW:0] sum;

    // Scan from farthest to nearest so the last hit is the closest to ptr_i
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        sum         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            if (req_i[sum[IW-1:0]]) begin
                grant_oh_o              = '0;
                grant_oh_o[sum[IW-1:0]] = 1'b1;
                grant_idx_o             = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ni_flit_rebuild_scheduler.sv
// Packet-atomic VC scheduler in front of the single flit rebuilder.
// Optional protocol checking/dropping enabled by NI_SCHED_PROTO_CHECK_EN.
//
// state     | meaning
// ST_IDLE   | no packet open; round-robin grant among eligible VCs
// ST_LOCKED | HEADER forwarded; only locked_vc is served until its TAIL
module ni_flit_rebuild_scheduler
    import ni_flit_rebuild_scheduler_pkg::*;
#(
    parameter int VC_NUM = NI_VC_NUM
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [VC_NUM-1:0]          vc_flit_valid_i,
    input  flit_t                      vc_flit_in_i [VC_NUM],
    output logic [VC_NUM-1:0]          vc_flit_ready_o,
    input  logic                       sched_stall_i,
    output logic                       sched_flit_valid_o,
    output flit_t                      sched_flit_out_o,
    output logic [$clog2(VC_NUM)-1:0]  sched_active_vc_o,
    output logic                       sched_busy_o,
    output logic                       sched_proto_error_o
);
    localparam int IW = $clog2(VC_NUM);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d, locked_vc_q, locked_vc_d;
    logic [IW-1:0]     active_vc_q, fwd_vc, grant_idx;
    logic [VC_NUM-1:0] elig, grant_oh, ready;
    logic              fwd_valid, flit_valid_q;
    flit_t             flit_out_q, fwd_flit;
    flit_type_e        fwd_type;
`ifdef NI_SCHED_PROTO_CHECK_EN
    logic [VC_NUM-1:0] drop;
    logic              proto_err_q;
`endif

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(VC_NUM - 1)) ? '0 : v + IW'(1);
    endfunction

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
`ifdef NI_SCHED_PROTO_CHECK_EN
            elig[v] = vc_flit_valid_i[v] && !flit_is_cont(vc_flit_in_i[v].header.flit_type);
`else
            elig[v] = vc_flit_valid_i[v];
`endif
        end
    end

    ni_rr_arbiter #(.N(VC_NUM)) u_rr_arbiter (
        .req_i       (elig),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx)
    );

    assign fwd_flit = vc_flit_in_i[fwd_vc];
    assign fwd_type = fwd_flit.header.flit_type;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            locked_vc_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_vc_q <= locked_vc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        locked_vc_d = locked_vc_q;
        case (state_q)
            ST_IDLE: begin
                if (fwd_valid) begin
                    if (fwd_type == FLIT_HEADER) begin
                        state_d     = ST_LOCKED;
                        locked_vc_d = fwd_vc;
                    end else begin
                        rr_ptr_d = wrap_inc(fwd_vc);
                    end
                end
            end
            ST_LOCKED: begin
                if (fwd_valid && fwd_type == FLIT_TAIL) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = wrap_inc(locked_vc_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forwarding honours stall; protocol drops bypass it and are never forwarded
    always_comb begin
        ready     = '0;
        fwd_valid = 1'b0;
        fwd_vc    = '0;
        case (state_q)
            ST_IDLE: begin
                fwd_vc = grant_idx;
                if (!sched_stall_i && (|grant_oh)) begin
                    ready     = grant_oh;
                    fwd_valid = 1'b1;
                end
            end
            ST_LOCKED: begin
                fwd_vc = locked_vc_q;
                if (vc_flit_valid_i[locked_vc_q] && !sched_stall_i
`ifdef NI_SCHED_PROTO_CHECK_EN
                    && flit_is_cont(vc_flit_in_i[locked_vc_q].header.flit_type)
`endif
                   ) begin
                    ready[locked_vc_q] = 1'b1;
                    fwd_valid          = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef NI_SCHED_PROTO_CHECK_EN
        drop = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (state_q == ST_LOCKED && IW'(v) == locked_vc_q) begin
                drop[v] = vc_flit_valid_i[v] && !flit_is_cont(vc_flit_in_i[v].header.flit_type);
            end else begin
                drop[v] = vc_flit_valid_i[v] && flit_is_cont(vc_flit_in_i[v].header.flit_type);
            end
        end
        ready = ready | drop;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_valid_q <= 1'b0;
            flit_out_q   <= '0;
            active_vc_q  <= '0;
        end else begin
            flit_valid_q <= fwd_valid;
            if (fwd_valid) begin
                flit_out_q  <= fwd_flit;
                active_vc_q <= fwd_vc;
            end
        end
    end

`ifdef NI_SCHED_PROTO_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_q | (|drop);
        end
    end
    assign sched_proto_error_o = proto_err_q;
`else
    assign sched_proto_error_o = 1'b0;
`endif

    assign vc_flit_ready_o    = ready;
    assign sched_flit_valid_o = flit_valid_q;
    assign sched_flit_out_o   = flit_out_q;
    assign sched_active_vc_o  = active_vc_q;
    assign sched_busy_o       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ni_flit_rebuild_scheduler.sv
// Self-checking bench for ni_flit_rebuild_scheduler: directed table, corner
// sequences and random traffic against a packet-level reference model.
module tb_ni_flit_rebuild_scheduler;
    import ni_flit_rebuild_scheduler_pkg::*;

    localparam int N = 4;
`ifdef NI_SCHED_PROTO_CHECK_EN
    localparam bit PROTO = 1'b1;
`else
    localparam bit PROTO = 1'b0;
`endif
    localparam logic [1:0] tH = 2'd0, tB = 2'd1, tT = 2'd2, tX = 2'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] valid, ready;
    flit_t        vc_in [N];
    logic         stall;
    logic         out_valid;
    flit_t        out_flit;
    logic [1:0]   act;
    logic         busy, perr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ni_flit_rebuild_scheduler #(.VC_NUM(N)) dut (
        .clk                 (clk),
        .reset               (reset),
        .vc_flit_valid_i     (valid),
        .vc_flit_in_i        (vc_in),
        .vc_flit_ready_o     (ready),
        .sched_stall_i       (stall),
        .sched_flit_valid_o  (out_valid),
        .sched_flit_out_o    (out_flit),
        .sched_active_vc_o   (act),
        .sched_busy_o        (busy),
        .sched_proto_error_o (perr)
    );

    // Reference model: a lock is either open on one VC or not
    bit           m_locked, m_err, m_vld, m_fwd, m_drop;
    int           m_lvc, m_rr, m_act, m_fv;
    flit_t        m_flit, m_nflit;
    logic [N-1:0] m_ready, s_ready;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_cont(input flit_type_e t);
        return (t == FLIT_BODY) || (t == FLIT_TAIL);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_vld = 0; m_lvc = 0; m_rr = 0; m_act = 0;
        m_flit = '0;
    endtask

    task automatic model_eval();
        m_ready = '0; m_fwd = 0; m_fv = 0; m_drop = 0;
        if (!m_locked) begin
            if (!stall) begin
                for (int k = 0; k < N; k++) begin
                    int v;
                    v = (m_rr + k) % N;
                    if (!m_fwd && valid[v] && !(PROTO && is_cont(vc_in[v].header.flit_type))) begin
                        m_fwd = 1; m_fv = v;
                    end
                end
            end
        end else if (valid[m_lvc] && !stall && !(PROTO && !is_cont(vc_in[m_lvc].header.flit_type))) begin
            m_fwd = 1; m_fv = m_lvc;
        end
        if (m_fwd) m_ready[m_fv] = 1'b1;
        if (PROTO) begin
            for (int v = 0; v < N; v++) begin
                bit own;
                own = m_locked && (v == m_lvc);
                if (valid[v] && (own ? !is_cont(vc_in[v].header.flit_type)
                                     : is_cont(vc_in[v].header.flit_type))) begin
                    m_ready[v] = 1'b1;
                    m_drop = 1;
                end
            end
        end
        m_nflit = vc_in[m_fv];
    endtask

    task automatic model_commit();
        m_vld = m_fwd;
        if (m_fwd) begin
            m_flit = m_nflit;
            m_act  = m_fv;
            if (!m_locked) begin
                if (m_nflit.header.flit_type == FLIT_HEADER) begin
                    m_locked = 1; m_lvc = m_fv;
                end else begin
                    m_rr = (m_fv + 1) % N;
                end
            end else if (m_nflit.header.flit_type == FLIT_TAIL) begin
                m_locked = 0; m_rr = (m_lvc + 1) % N;
            end
        end
        if (m_drop) m_err = 1;
    endtask

    task automatic drive(input logic [3:0] vld, input logic [7:0] types, input logic st, input int tag);
        stall = st;
        for (int v = 0; v < N; v++) begin
            valid[v]                   = vld[v];
            vc_in[v].header.flit_type  = flit_type_e'(types[2*v +: 2]);
            vc_in[v].header.src_id     = 6'(v);
            vc_in[v].payload           = 32'(tag * 16 + v);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1
    task automatic step();
        #2;
        model_eval();
        s_ready = ready;
        chk("ready", ready, m_ready);
        @(posedge clk);
        #1;
        model_commit();
        chk("valid", out_valid, m_vld);
        chk("flit", out_flit, m_flit);
        chk("active_vc", act, m_act);
        chk("busy", busy, m_locked);
        chk("proto_err", perr, m_err);
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [7:0] ty;
        logic       st;
        logic [3:0] rdy;
        logic       ov;
        int         av;
        logic       bsy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // single HT, 3+3 contention with a stall, then RR fairness over four HTs
        tbl[0]  = '{4'b0100, {tH, tX, tH, tH}, 1'b0, 4'b0100, 1'b1, 2, 1'b0};
        tbl[1]  = '{4'b0000, {tH, tH, tH, tH}, 1'b0, 4'b0000, 1'b0, 2, 1'b0};
        tbl[2]  = '{4'b0011, {tH, tH, tH, tH}, 1'b0, 4'b0001, 1'b1, 0, 1'b1};
        tbl[3]  = '{4'b0011, {tH, tH, tH, tB}, 1'b0, 4'b0001, 1'b1, 0, 1'b1};
        tbl[4]  = '{4'b0011, {tH, tH, tH, tT}, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
        tbl[5]  = '{4'b0010, {tH, tH, tH, tH}, 1'b0, 4'b0010, 1'b1, 1, 1'b1};
        tbl[6]  = '{4'b0010, {tH, tH, tB, tH}, 1'b1, 4'b0000, 1'b0, 1, 1'b1};
        tbl[7]  = '{4'b0010, {tH, tH, tB, tH}, 1'b0, 4'b0010, 1'b1, 1, 1'b1};
        tbl[8]  = '{4'b0010, {tH, tH, tT, tH}, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
        tbl[9]  = '{4'b1111, {tX, tX, tX, tX}, 1'b0, 4'b0100, 1'b1, 2, 1'b0};
        tbl[10] = '{4'b1111, {tX, tX, tX, tX}, 1'b0, 4'b1000, 1'b1, 3, 1'b0};
        tbl[11] = '{4'b1111, {tX, tX, tX, tX}, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
        tbl[12] = '{4'b1111, {tX, tX, tX, tX}, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
        tbl[13] = '{4'b0000, {tH, tH, tH, tH}, 1'b0, 4'b0000, 1'b0, 1, 1'b0};

        reset = 1'b1;
        drive(4'b0000, 8'h00, 1'b0, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_flit", out_flit, 40'h0);
        chk("rst_active", act, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_perr", perr, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].ty, tbl[i].st, 100 + i);
            step();
            chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_active", i), act, tbl[i].av);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
        end

        // VC3 packet with a 2-cycle stall while VC0 keeps offering HT
        drive(4'b1000, {tH, tH, tH, tH}, 1'b0, 200); step();
        chk("stl_busy", busy, 1'b1);
        chk("stl_active", act, 2'd3);
        drive(4'b1001, {tB, tH, tH, tX}, 1'b0, 201); step();
        for (int s = 0; s < 2; s++) begin
            drive(4'b1001, {tB, tH, tH, tX}, 1'b1, 202); step();
            chk("stl_ready", s_ready, 4'b0000);
            chk("stl_valid", out_valid, 1'b0);
            chk("stl_lock", busy, 1'b1);
        end
        drive(4'b1001, {tB, tH, tH, tX}, 1'b0, 203); step();
        chk("stl_resume_ready", s_ready, 4'b1000);
        chk("stl_resume_payload", out_flit.payload, 32'(203 * 16 + 3));
        drive(4'b1001, {tT, tH, tH, tX}, 1'b0, 204); step();
        chk("stl_tail_type", out_flit.header.flit_type, FLIT_TAIL);
        chk("stl_tail_busy", busy, 1'b0);

        // Reset in the middle of a VC2 packet
        drive(4'b0100, {tH, tH, tH, tH}, 1'b0, 300); step();
        drive(4'b0100, {tH, tB, tH, tH}, 1'b0, 301); step();
        drive(4'b0100, {tH, tB, tH, tH}, 1'b0, 302);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_flit", out_flit, 40'h0);
        chk("mid_rst_active", act, 2'd0);
        chk("mid_rst_busy", busy, 1'b0);
        model_reset();
        drive(4'b0000, 8'h00, 1'b0, 303);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b1010, {tH, tH, tH, tH}, 1'b0, 304); step();
        chk("post_rst_ready", s_ready, 4'b0010);
        chk("post_rst_active", act, 2'd1);
        drive(4'b0010, {tH, tH, tT, tH}, 1'b0, 305); step();
        chk("post_rst_busy", busy, 1'b0);

`ifdef NI_SCHED_PROTO_CHECK_EN
        drive(4'b0100, {tH, tB, tH, tH}, 1'b1, 400); step();
        chk("proto_ready", s_ready, 4'b0100);
        chk("proto_valid", out_valid, 1'b0);
        chk("proto_err", perr, 1'b1);
        drive(4'b0000, 8'h00, 1'b0, 401); step(); step();
        chk("proto_sticky", perr, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("proto_clear", perr, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
`endif

        for (int c = 0; c < 800; c++) begin
            drive(4'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0), 1000 + c);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
